spi_accel_responder: RTL

- SPI responder (slave) modelling the ADXL345 3-wire SPI interface, mode 3.
- Answers the team's ADXL SPI initiator. Used as the bench/loopback target for the initiator and as an FPGA-side accelerometer emulator.
- Holds a 64-byte register map, loads X/Y/Z samples from a local source, and exposes the control registers.

---
 rtl/spi_accel_responder.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_accel_responder.sv
`timescale 1ns/1ps
// ADXL345-style 3-wire SPI responder (mode 3) with a 64-byte register map.
// Define SPI_SNAPSHOT_EN to make multi-byte X/Y/Z reads coherent within a frame.
//
// state | meaning
// IDLE  | CS high, waiting for synced CS low
// CMD   | shifting in the command byte
// RDATA | driving read bytes on SCLK falls
// WDATA | shifting in write bytes on SCLK rises
module spi_accel_responder #(
    parameter logic [7:0] DEVID       = 8'hE5,
    parameter logic [7:0] BW_RATE_RST = 8'h0A
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cs_ni,
    input  logic        sclk_i,
    input  logic        sdio_i,
    output logic        sdio_o,
    output logic        sdio_oe_o,
    input  logic [15:0] sample_x_i,
    input  logic [15:0] sample_y_i,
    input  logic [15:0] sample_z_i,
    input  logic        sample_valid_i,
    output logic        wr_stb_o,
    output logic [5:0]  wr_addr_o,
    output logic [7:0]  wr_data_o,
    output logic [7:0]  bw_rate_o,
    output logic [7:0]  power_ctl_o,
    output logic [7:0]  data_format_o
);
    typedef enum logic [1:0] {IDLE, CMD, RDATA, WDATA} state_t;

    state_t      state;
    logic [1:0]  cs_sync, sclk_sync, sdio_sync;
    logic        sclk_prev;
    logic        cs_s, sclk_s, sdio_s, sclk_rise, sclk_fall;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic [7:0]  shift_in;
    logic [5:0]  addr, addr_next, cmd_addr;
    logic        mb;
    logic [7:0]  regs [64];
    logic [7:0]  data_regs [6];
    logic [7:0]  data_view [6];
`ifdef SPI_SNAPSHOT_EN
    logic [7:0]  snap [6];
    logic        snap_active;
`endif

    assign cs_s      = cs_sync[1];
    assign sclk_s    = sclk_sync[1];
    assign sdio_s    = sdio_sync[1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign shift_in  = {shift[6:0], sdio_s};
    assign cmd_addr  = shift_in[5:0];
    assign addr_next = mb ? addr + 6'd1 : addr;

    assign bw_rate_o     = regs[6'h2C];
    assign power_ctl_o   = regs[6'h2D];
    assign data_format_o = regs[6'h31];

    always_comb begin
        for (int i = 0; i < 6; i++) begin
`ifdef SPI_SNAPSHOT_EN
            data_view[i] = snap_active ? snap[i] : data_regs[i];
`else
            data_view[i] = data_regs[i];
`endif
        end
    end

    function automatic logic is_writable(input logic [5:0] a);
        return ((a >= 6'h1D) && (a <= 6'h2F) && (a != 6'h2B)) || (a == 6'h31) || (a == 6'h38);
    endfunction

    function automatic logic [7:0] read_mux(input logic [5:0] a);
        logic [2:0] di;
        di = 3'(a - 6'h32);
        if (a == 6'h00)
            return DEVID;
        else if ((a >= 6'h32) && (a <= 6'h37))
            return data_view[di];
        else if (is_writable(a))
            return regs[a];
        else
            return 8'h00;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cs_sync   <= 2'b11;
            sclk_sync <= 2'b11;
            sdio_sync <= 2'b00;
            sclk_prev <= 1'b1;
        end else begin
            cs_sync   <= {cs_sync[0], cs_ni};
            sclk_sync <= {sclk_sync[0], sclk_i};
            sdio_sync <= {sdio_sync[0], sdio_i};
            sclk_prev <= sclk_s;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shift     <= 8'h00;
            addr      <= 6'h00;
            mb        <= 1'b0;
            sdio_o    <= 1'b0;
            sdio_oe_o <= 1'b0;
            wr_stb_o  <= 1'b0;
            wr_addr_o <= 6'h00;
            wr_data_o <= 8'h00;
            for (int i = 0; i < 64; i++)
                regs[6'(i)] <= (i == 'h2C) ? BW_RATE_RST : 8'h00;
            for (int i = 0; i < 6; i++)
                data_regs[3'(i)] <= 8'h00;
`ifdef SPI_SNAPSHOT_EN
            for (int i = 0; i < 6; i++)
                snap[3'(i)] <= 8'h00;
            snap_active <= 1'b0;
`endif
        end else begin
            wr_stb_o <= 1'b0;
            if (sample_valid_i) begin
                data_regs[0] <= sample_x_i[7:0];
                data_regs[1] <= sample_x_i[15:8];
                data_regs[2] <= sample_y_i[7:0];
                data_regs[3] <= sample_y_i[15:8];
                data_regs[4] <= sample_z_i[7:0];
                data_regs[5] <= sample_z_i[15:8];
            end
            // CS deassertion wins over any SCLK edge, so partial bytes are dropped
            if (cs_s) begin
                state     <= IDLE;
                sdio_oe_o <= 1'b0;
`ifdef SPI_SNAPSHOT_EN
                snap_active <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        state   <= CMD;
                        bit_cnt <= 3'd0;
                    end
                    CMD: if (sclk_rise) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        shift   <= shift_in;
                        if (bit_cnt == 3'd7) begin
                            mb   <= shift_in[6];
                            addr <= cmd_addr;
                            if (shift_in[7]) begin
                                state <= RDATA;
                                shift <= read_mux(cmd_addr);
`ifdef SPI_SNAPSHOT_EN
                                if ((cmd_addr >= 6'h32) && (cmd_addr <= 6'h37)) begin
                                    snap_active <= 1'b1;
                                    for (int i = 0; i < 6; i++)
                                        snap[3'(i)] <= data_regs[3'(i)];
                                end
`endif
                            end else begin
                                state <= WDATA;
                            end
                        end
                    end
                    RDATA: begin
                        if (sclk_fall) begin
                            sdio_oe_o <= 1'b1;
                            sdio_o    <= shift[7];
                            shift     <= {shift[6:0], 1'b0};
                        end else if (sclk_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                addr  <= addr_next;
                                shift <= read_mux(addr_next);
                            end
                        end
                    end
                    WDATA: if (sclk_rise) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        shift   <= shift_in;
                        if (bit_cnt == 3'd7) begin
                            if (is_writable(addr)) begin
                                regs[addr] <= shift_in;
                                wr_stb_o   <= 1'b1;
                                wr_addr_o  <= addr;
                                wr_data_o  <= shift_in;
                            end
                            addr <= addr_next;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
